// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
// Handles load-use stalls, EX taken-branch flushes and mult/div front-end holds.
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_flush,
  output logic             exmem_wen,
  output logic             exmem_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MC_W = $clog2(MD_LATENCY) + 1;
  localparam logic [MC_W-1:0] MD_INIT = MC_W'(MD_LATENCY - 1);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t            r_state, w_state_nxt;
  logic [MC_W-1:0]   r_md_cnt, w_md_cnt_nxt;
  logic [CNT_W-1:0]  r_stall_count;
  logic              w_lu_haz;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_lu_haz = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    pc_wen       = 1'b1;
    ifid_wen     = 1'b1;
    ifid_flush   = 1'b0;
    idex_wen     = 1'b1;
    idex_flush   = 1'b0;
    exmem_wen    = 1'b1;
    exmem_flush  = 1'b0;
    md_busy      = 1'b0;
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;

    if (reset) begin
      pc_wen       = 1'b0;
      ifid_wen     = 1'b0;
      idex_wen     = 1'b0;
      exmem_wen    = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      w_state_nxt  = RUN;
      w_md_cnt_nxt = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_branch_taken) begin
            // squashes the ID instruction, so its hazards and md start are moot
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (w_lu_haz) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_flush = 1'b1;
          end else if (id_md_start && (MD_LATENCY > 1)) begin
            w_state_nxt  = MD_BUSY;
            w_md_cnt_nxt = MD_INIT;
          end
        end
        MD_BUSY: begin
          pc_wen      = 1'b0;
          ifid_wen    = 1'b0;
          idex_wen    = 1'b0;
          exmem_flush = 1'b1;
          md_busy     = 1'b1;
          if (r_md_cnt == MC_W'(1)) begin
            w_state_nxt  = RUN;
            w_md_cnt_nxt = '0;
          end else begin
            w_md_cnt_nxt = r_md_cnt - MC_W'(1);
          end
        end
        default: begin
          w_state_nxt  = RUN;
          w_md_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= RUN;
      r_md_cnt      <= '0;
      r_stall_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (!pc_wen && (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule
